// File: rtl/axis_pkt_sink.sv
// Single-packet AXI4-Stream sink: buffers one packet, flags sequence/length/strobe
// errors, then replays the buffered words on a valid/ready output port.
module axis_pkt_sink #(
  parameter int C_S_AXIS_TDATA_WIDTH  = 32,
  parameter int NUMBER_OF_INPUT_WORDS = 8,
  parameter int PKT_COUNT_WIDTH       = 16
) (
  input  logic                              S_AXIS_ACLK,
  input  logic                              S_AXIS_ARESET,
  input  logic                              S_AXIS_TVALID,
  output logic                              S_AXIS_TREADY,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic                              S_AXIS_TLAST,
  output logic                              OUT_VALID,
  input  logic                              OUT_READY,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]   OUT_DATA,
  output logic                              OUT_LAST,
  output logic [PKT_COUNT_WIDTH-1:0]        PKT_COUNT,
  output logic                              ERR_SEQ,
  output logic                              ERR_LEN,
  output logic                              ERR_STRB,
  input  logic                              CLR_ERR
);
  // state | meaning
  // RECV  | TREADY high (after a one-cycle settle), filling the buffer
  // DRAIN | TREADY low, replaying buffer[0..pkt_len-1] on OUT_*
  localparam int DW = C_S_AXIS_TDATA_WIDTH;
  localparam int N  = NUMBER_OF_INPUT_WORDS;
  localparam int PW = $clog2(N) + 1;
  localparam int AW = PW - 1;

  typedef enum logic {RECV = 1'b0, DRAIN = 1'b1} state_t;
  state_t r_state, w_state_nxt;

  logic [DW-1:0]              r_buf [N];
  logic [PW-1:0]              r_wr_ptr, r_rd_ptr, r_pkt_len;
  logic                       r_tready, r_out_valid;
  logic [PKT_COUNT_WIDTH-1:0] r_pkt_count;
  logic                       r_err_seq, r_err_len, r_err_strb;

  logic          w_accept, w_full, w_pkt_end, w_xfer, w_out_last;
  logic [DW-1:0] w_expect;
  logic          w_seq_bad, w_strb_bad, w_len_bad;

  assign w_accept   = S_AXIS_TVALID && r_tready;
  assign w_full     = (r_wr_ptr == PW'(N - 1));
  assign w_pkt_end  = w_accept && (S_AXIS_TLAST || w_full);
  assign w_expect   = DW'(r_wr_ptr) + DW'(1);
  assign w_seq_bad  = w_accept && (S_AXIS_TDATA != w_expect);
  assign w_strb_bad = w_accept && (S_AXIS_TSTRB != '1);
  // TLAST must coincide exactly with the Nth word: early or missing are both errors
  assign w_len_bad  = w_accept && (S_AXIS_TLAST != w_full);
  assign w_out_last = r_out_valid && (r_rd_ptr == r_pkt_len - PW'(1));
  assign w_xfer     = r_out_valid && OUT_READY;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RECV:    if (w_pkt_end) w_state_nxt = DRAIN;
      DRAIN:   if (w_xfer && w_out_last) w_state_nxt = RECV;
      default: w_state_nxt = RECV;
    endcase
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      r_state     <= RECV;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_pkt_len   <= '0;
      r_tready    <= 1'b0;
      r_out_valid <= 1'b0;
      r_pkt_count <= '0;
      r_err_seq   <= 1'b0;
      r_err_len   <= 1'b0;
      r_err_strb  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tready    <= (w_state_nxt == RECV);
      r_out_valid <= (w_state_nxt == DRAIN);
      if (w_accept) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pkt_end) r_pkt_len <= r_wr_ptr + PW'(1);
      if (w_xfer) begin
        if (w_out_last) begin
          r_rd_ptr    <= '0;
          r_wr_ptr    <= '0;
          r_pkt_count <= r_pkt_count + PKT_COUNT_WIDTH'(1);
        end else begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
      end
      // a new error event in the clearing cycle wins over the clear
      r_err_seq  <= w_seq_bad  || (r_err_seq  && !CLR_ERR);
      r_err_len  <= w_len_bad  || (r_err_len  && !CLR_ERR);
      r_err_strb <= w_strb_bad || (r_err_strb && !CLR_ERR);
    end
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (w_accept) r_buf[r_wr_ptr[AW-1:0]] <= S_AXIS_TDATA;
  end

  assign S_AXIS_TREADY = r_tready;
  assign OUT_VALID     = r_out_valid;
  assign OUT_DATA      = r_out_valid ? r_buf[r_rd_ptr[AW-1:0]] : '0;
  assign OUT_LAST      = w_out_last;
  assign PKT_COUNT     = r_pkt_count;
  assign ERR_SEQ       = r_err_seq;
  assign ERR_LEN       = r_err_len;
  assign ERR_STRB      = r_err_strb;

endmodule

// File: tb/tb_axis_pkt_sink.sv
// Bench for axis_pkt_sink: queue-based packet model checked every cycle, plus
// directed scenarios with literal expectations and a randomized packet run.
module tb_axis_pkt_sink;
  localparam int DW = 32;
  localparam int N  = 8;
  localparam int CW = 16;

  logic          clk = 1'b0, rst = 1'b1;
  logic          tvalid = 1'b0, tlast = 1'b0, ordy = 1'b0, clr = 1'b0;
  logic [DW-1:0] tdata = '0;
  logic [3:0]    tstrb = '0;
  logic          tready, out_valid, out_last, err_seq, err_len, err_strb;
  logic [DW-1:0] out_data;
  logic [CW-1:0] pkt_count;

  always #5 clk = ~clk;

  axis_pkt_sink #(
    .C_S_AXIS_TDATA_WIDTH(DW), .NUMBER_OF_INPUT_WORDS(N), .PKT_COUNT_WIDTH(CW)
  ) dut (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .S_AXIS_TVALID(tvalid),
    .S_AXIS_TREADY(tready), .S_AXIS_TDATA(tdata), .S_AXIS_TSTRB(tstrb),
    .S_AXIS_TLAST(tlast), .OUT_VALID(out_valid), .OUT_READY(ordy),
    .OUT_DATA(out_data), .OUT_LAST(out_last), .PKT_COUNT(pkt_count),
    .ERR_SEQ(err_seq), .ERR_LEN(err_len), .ERR_STRB(err_strb), .CLR_ERR(clr)
  );

  typedef struct packed {logic [31:0] d; logic [3:0] s; logic l;} word_t;
  word_t       sq[$];
  logic [31:0] cur[$], outq[$], olog[$];
  bit m_ready, m_drain, m_acc, m_in_rst, m_eseq, m_elen, m_estrb, started;
  int m_cnt, m_nacc;
  int ntests, nfail;
  int valid_mode, ordy_mode, pat_idx;
  bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Packet-level model: words collect into cur until TLAST or N words, then the whole
  // packet moves to outq and is popped one word per consumer handshake.
  task automatic model_step();
    bit sseq, slen, sstrb;
    sseq = 0; slen = 0; sstrb = 0; m_acc = 0;
    m_in_rst = rst;
    if (rst) begin
      m_ready = 0; m_drain = 0; cur.delete(); outq.delete();
      m_cnt = 0; m_eseq = 0; m_elen = 0; m_estrb = 0;
      return;
    end
    if (!m_drain) begin
      if (m_ready && tvalid) begin
        m_acc = 1; m_nacc++;
        if (sq.size() > 0) void'(sq.pop_front());
        if (tdata != 32'(cur.size() + 1)) sseq = 1;
        if (tstrb != 4'hF) sstrb = 1;
        cur.push_back(tdata);
        if (tlast || cur.size() == N) begin
          if (!tlast || cur.size() < N) slen = 1;
          outq = cur; cur.delete();
          m_drain = 1; m_ready = 0;
        end else m_ready = 1;
      end else m_ready = 1;
    end else if (ordy) begin
      olog.push_back(outq.pop_front());
      if (outq.size() == 0) begin
        m_drain = 0; m_ready = 1; m_cnt++;
      end
    end
    m_eseq  = sseq  | (m_eseq  & !clr);
    m_elen  = slen  | (m_elen  & !clr);
    m_estrb = sstrb | (m_estrb & !clr);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
    started = 1;
  end

  // Compare then drive, both on the falling edge.
  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("tready", tready, m_ready);
      chk("out_valid", out_valid, m_drain);
      if (m_drain) begin
        chk("out_data", out_data, outq[0]);
        chk("out_last", out_last, outq.size() == 1);
      end
      if (m_in_rst) begin
        chk("out_data_rst", out_data, 0);
        chk("out_last_rst", out_last, 0);
      end
      chk("pkt_count", pkt_count, m_cnt & 32'hFFFF);
      chk("err_seq", err_seq, m_eseq);
      chk("err_len", err_len, m_elen);
      chk("err_strb", err_strb, m_estrb);
    end
    if (!(tvalid && !m_acc && sq.size() > 0)) begin
      if (sq.size() > 0 && (valid_mode == 0 || $urandom_range(0, 3) != 0)) begin
        tvalid = 1'b1;
        {tdata, tstrb, tlast} = sq[0];
      end else tvalid = 1'b0;
    end
    case (ordy_mode)
      0: ordy = 1'b1;
      1: ordy = 1'($urandom_range(0, 1));
      default: begin ordy = pat[pat_idx]; pat_idx = (pat_idx + 1) % 6; end
    endcase
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push_word(input logic [31:0] d, input logic [3:0] s, input logic l);
    word_t w;
    w.d = d; w.s = s; w.l = l;
    sq.push_back(w);
  endtask

  task automatic push_seq(input int first, input int last, input int last_at);
    for (int i = first; i <= last; i++) push_word(i, 4'hF, i == last_at);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (4) step();
    sq.delete();
    repeat (2) step();
    rst = 1'b0;
    step();
    olog.delete();
  endtask

  task automatic wait_idle(input string nm, input int budget, input bit rand_clr);
    int n = 0;
    while ((sq.size() > 0 || m_drain || cur.size() > 0) && n < budget) begin
      clr = rand_clr ? ($urandom_range(0, 15) == 0) : 1'b0;
      step(); n++;
    end
    clr = 1'b0;
    chk({nm, "_timeout"}, n < budget, 1);
  endtask

  task automatic check_log(input string nm, input logic [31:0] exp[$]);
    chk({nm, "_len"}, olog.size(), exp.size());
    for (int i = 0; i < exp.size() && i < olog.size(); i++) chk({nm, "_word"}, olog[i], exp[i]);
  endtask

  initial begin
    logic [31:0] e[$];
    int n, npk, len;
    valid_mode = 0; ordy_mode = 0; pat_idx = 0;

    // reset state
    repeat (4) step();
    chk("rst_tready", tready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_pkt_count", pkt_count, 0);
    rst = 1'b0;
    step();
    chk("rst_tready_after", tready, 1);

    // 1: clean packet, consumer always ready
    do_reset();
    push_seq(1, 8, 8);
    wait_idle("t1", 200, 0);
    e = '{1, 2, 3, 4, 5, 6, 7, 8};
    check_log("t1_log", e);
    chk("t1_cnt", pkt_count, 1);
    chk("t1_errs", {err_seq, err_len, err_strb}, 0);
    chk("t1_tready", tready, 1);

    // 2: consumer stalls
    do_reset();
    ordy_mode = 2; pat_idx = 0;
    push_seq(1, 8, 8);
    wait_idle("t2", 200, 0);
    check_log("t2_log", e);
    chk("t2_cnt", pkt_count, 1);
    ordy_mode = 0;

    // 3: early TLAST
    do_reset();
    push_seq(1, 5, 5);
    wait_idle("t3", 200, 0);
    e = '{1, 2, 3, 4, 5};
    check_log("t3_log", e);
    chk("t3_cnt", pkt_count, 1);
    chk("t3_err_len", err_len, 1);
    chk("t3_err_seq", err_seq, 0);

    // 4: missing TLAST, 9th word starts the next packet
    do_reset();
    push_seq(1, 9, 0);
    push_seq(2, 8, 8);
    wait_idle("t4", 300, 0);
    e = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 2, 3, 4, 5, 6, 7, 8};
    check_log("t4_log", e);
    chk("t4_cnt", pkt_count, 2);
    chk("t4_err_len", err_len, 1);
    chk("t4_err_seq", err_seq, 1);

    // 5: bad data and strobe, clear, then set-wins
    do_reset();
    for (int i = 1; i <= 8; i++)
      push_word((i == 3) ? 32'h55 : 32'(i), (i == 6) ? 4'b0111 : 4'hF, i == 8);
    wait_idle("t5", 200, 0);
    e = '{1, 2, 32'h55, 4, 5, 6, 7, 8};
    check_log("t5_log", e);
    chk("t5_err_seq", err_seq, 1);
    chk("t5_err_strb", err_strb, 1);
    chk("t5_err_len", err_len, 0);
    clr = 1'b1; step(); clr = 1'b0;
    chk("t5_clr", {err_seq, err_len, err_strb}, 0);
    push_word(32'h99, 4'hF, 1'b1);
    clr = 1'b1;
    n = 0;
    while (!m_acc && n < 20) begin step(); n++; end
    chk("t5_acc_timeout", n < 20, 1);
    chk("t5_set_wins_seq", err_seq, 1);
    chk("t5_set_wins_len", err_len, 1);
    clr = 1'b0;
    wait_idle("t5b", 100, 0);

    // 6: reset mid-packet
    do_reset();
    m_nacc = 0;
    push_seq(1, 8, 8);
    n = 0;
    while (m_nacc < 3 && n < 50) begin step(); n++; end
    chk("t6_acc_timeout", n < 50, 1);
    rst = 1'b1;
    step(); step();
    chk("t6_tready", tready, 0);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_cnt_rst", pkt_count, 0);
    chk("t6_errs_rst", {err_seq, err_len, err_strb}, 0);
    sq.delete();
    step(); step();
    rst = 1'b0;
    step();
    olog.delete();
    push_seq(1, 8, 8);
    wait_idle("t6", 200, 0);
    e = '{1, 2, 3, 4, 5, 6, 7, 8};
    check_log("t6_log", e);
    chk("t6_cnt", pkt_count, 1);

    // 7: random packets, random gaps, random consumer, random clears
    do_reset();
    valid_mode = 1; ordy_mode = 1;
    npk = 0;
    for (int p = 0; p < 25; p++) begin
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++)
        push_word(($urandom_range(0, 7) == 0) ? $urandom : 32'((i % N) + 1),
                  ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hF, i == len - 1);
      npk += (len > N) ? 2 : 1;
    end
    wait_idle("t7", 8000, 1);
    chk("t7_cnt", pkt_count, npk);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/axis_pkt_sink.md
Name: axis_pkt_sink

Overview:
- AXI4-Stream slave that sits directly downstream of the team's 8-word stream generator.
- Accepts one packet at a time into an internal buffer and checks it for sequence, length and strobe errors.
- After the packet is complete, forwards the buffered words on a simple valid/ready output port.
- Provides a packet counter and sticky error flags for the test harness and for status registers.

Parameters:
- C_S_AXIS_TDATA_WIDTH, 32, width of TDATA and OUT_DATA (multiple of 8).
- NUMBER_OF_INPUT_WORDS, 8, buffer depth and expected packet length (power of 2, >= 2).
- PKT_COUNT_WIDTH, 16, width of PKT_COUNT.

Ports:
- S_AXIS_ACLK  in  1  sole clock; all logic on the rising edge.
- S_AXIS_ARESET  in  1  synchronous reset, active-high.
- S_AXIS_TVALID  in  1  upstream word valid.
- S_AXIS_TREADY  out  1  block ready to accept (registered).
- S_AXIS_TDATA  in  C_S_AXIS_TDATA_WIDTH  upstream data.
- S_AXIS_TSTRB  in  C_S_AXIS_TDATA_WIDTH/8  byte strobes.
- S_AXIS_TLAST  in  1  last word of packet.
- OUT_VALID  out  1  buffered word available.
- OUT_READY  in  1  consumer accepts word.
- OUT_DATA  out  C_S_AXIS_TDATA_WIDTH  buffered word.
- OUT_LAST  out  1  final buffered word of packet.
- PKT_COUNT  out  PKT_COUNT_WIDTH  packets fully drained.
- ERR_SEQ  out  1  sticky: data word != expected value.
- ERR_LEN  out  1  sticky: TLAST early or missing.
- ERR_STRB  out  1  sticky: TSTRB not all-ones.
- CLR_ERR  in  1  single-cycle clear of the sticky error flags.

Behaviour:
- Reset (S_AXIS_ARESET=1 on a clock edge):
  - state=RECV; wr_ptr=0, rd_ptr=0, pkt_len=0.
  - S_AXIS_TREADY=0, OUT_VALID=0, OUT_LAST=0, OUT_DATA=0.
  - PKT_COUNT=0; ERR_SEQ, ERR_LEN, ERR_STRB all 0.
  - Buffer contents are don't-care.
  - Reset mid-packet discards all buffered data. No partial output; no count increment.
- States: RECV, DRAIN.
- RECV:
  - S_AXIS_TREADY is driven 1 starting the first cycle after reset deasserts, and the first cycle after a drain completes.
  - accept = S_AXIS_TVALID && S_AXIS_TREADY.
  - On accept: buffer[wr_ptr] <= TDATA; wr_ptr increments.
  - Sequence check: expected word value is wr_ptr+1, zero-extended to data width (the generator emits 1..N). Mismatch sets ERR_SEQ.
  - Strobe check: TSTRB != all-ones sets ERR_STRB. The word is still stored.
  - Packet end, case 1: TLAST=1 on an accept with wr_ptr < N-1. Sets ERR_LEN; pkt_len = wr_ptr+1.
  - Packet end, case 2: accept at wr_ptr == N-1. pkt_len = N. If TLAST=0 there, set ERR_LEN (forced termination).
  - On either packet end: S_AXIS_TREADY=0 and state=DRAIN from the next cycle. No word is accepted after the ending word.
  - Words following a forced termination wait upstream and form the start of the next packet.
- DRAIN:
  - OUT_VALID=1 starting the cycle after the ending accept (1-cycle latency).
  - OUT_DATA = buffer[rd_ptr]; OUT_LAST = (rd_ptr == pkt_len-1).
  - Transfer = OUT_VALID && OUT_READY; rd_ptr increments on each transfer.
  - OUT_VALID, OUT_DATA and OUT_LAST hold stable while OUT_READY=0.
  - On the transfer with OUT_LAST=1, in the next cycle: OUT_VALID=0, state=RECV, wr_ptr=rd_ptr=0, S_AXIS_TREADY=1, PKT_COUNT+1.
  - PKT_COUNT wraps modulo 2^PKT_COUNT_WIDTH.
  - Minimum gap between packets: one idle TREADY=0 cycle after the ending accept, plus the drain time.
- Error flags:
  - Sticky until CLR_ERR=1.
  - If CLR_ERR and a new error event occur in the same cycle, set wins.
  - Errors do not stall the datapath.
- Pointer widths: $clog2(N)+1 bits. No wrap within a packet, since termination occurs at N.

Test Plan:
1. Reset 4 cycles; send 1..8 with TLAST on 8th, OUT_READY=1.
   -> TREADY=1 for 8 accepts, then 0.
   -> OUT emits 1..8 on consecutive cycles starting 1 cycle after the 8th accept, OUT_LAST on 8.
   -> PKT_COUNT=1; all ERR flags=0.
   -> TREADY returns to 1 one cycle after the last output.
2. Same packet with OUT_READY pattern 1,0,0,1,0,1...
   -> OUT_DATA and OUT_LAST stable during stalls.
   -> output order 1..8 with no loss or duplicate; PKT_COUNT=1.
3. Send 1..5 with TLAST on 5.
   -> ERR_LEN=1; output 1..5 with OUT_LAST on 5; PKT_COUNT=1; ERR_SEQ=0.
4. Send 1..9 with no TLAST.
   -> ERR_LEN=1; output 1..8 with OUT_LAST on 8.
   -> word 9 is held upstream until the drain ends, then accepted as word 0 of the next packet.
   -> ERR_SEQ=1 (9 != 1).
5. Packet with word 3 = 0x55 and word 6 with TSTRB=4'b0111.
   -> ERR_SEQ=1, ERR_STRB=1; data still forwarded unchanged.
   -> CLR_ERR pulse clears both flags.
   -> CLR_ERR in the same cycle as a new bad word leaves the flag = 1.
6. Assert reset after 3 accepts.
   -> TREADY=0, OUT_VALID=0, PKT_COUNT=0, flags 0 during reset.
   -> next clean 1..8 packet drains correctly with PKT_COUNT=1.
